vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Free-running VGA raster timing generator: it produces the horizontal/vertical pixel position counters, sync pulses and display-enable that downstream character-box detectors, ROM fetch logic and the HDMI encoder consume. It divides the system clock down to a pixel-rate enable, so the whole video path runs on one clock with clock enables. Default timing is 640x480@60 Hz (800x525 total) with a 25 MHz pixel rate from a 100 MHz clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, system clocks per pixel, legal range 1..16
- `SYNC_ACTIVE`, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- `clk` input 1: system clock, all logic on the rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `h_val` output 10: current pixel column, 0..H_TOTAL-1
- `v_val` output 10: current line, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync at SYNC_ACTIVE level during the sync interval
- `vsync` output 1: vertical sync at SYNC_ACTIVE level during the sync interval
- `video_on` output 1: high when h_val < H_ACTIVE and v_val < V_ACTIVE
- `pix_tick` output 1: one-clk strobe on the first clk of each new pixel
- `line_start` output 1: one-clk strobe when h_val becomes 0
- `frame_start` output 1: one-clk strobe when (h_val, v_val) becomes (0, 0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is the vertical equivalent (525). Both must be ≤ 1024; anything larger is a parameter error (elaboration assertion).
- Divider counter `div` runs 0..CLK_DIV-1 and wraps. An internal advance enable is high when div == CLK_DIV-1. With CLK_DIV = 1 the enable is always high.
- On an advance:
  - h_val increments; at H_TOTAL-1 it wraps to 0.
  - v_val increments only on the h wrap; at V_TOTAL-1 (with h wrap) it wraps to 0.
- hsync is active when h_val ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
- vsync is active when v_val ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491]. vsync changes only together with an h wrap.
- All outputs are registered. Decodes are computed from the next-state counter values, so the sync, video_on and strobe outputs are always consistent with h_val/v_val in the same clk cycle. There is no skew between counters and decodes.
- line_start and frame_start are only ever high in cycles where pix_tick is high.

## Timing
- Reset values:
  - div = 0
  - h_val = H_TOTAL-1 (799), v_val = V_TOTAL-1 (524)
  - hsync = vsync = !SYNC_ACTIVE
  - video_on = 0
  - pix_tick = line_start = frame_start = 0
- After rst_n deasserts, the first advance occurs on the CLK_DIV-th rising edge. Counters then become (0,0), and pix_tick, line_start, frame_start and video_on all go high in that same cycle.
- Each pixel lasts exactly CLK_DIV clks. pix_tick is high in the first clk of each pixel only (constantly high when CLK_DIV = 1).
- One line = H_TOTAL × CLK_DIV clks (3200). One frame = 1,680,000 clks.
- A reset assertion mid-frame forces the reset values immediately (asynchronously). Any partial line is discarded, and the next frame restarts cleanly.

## Structure
- `vga_timing_pkg` holds the default timing constants and a localparam function computing H_TOTAL/V_TOTAL, so the box detectors and ROM address logic share the same numbers.
- Sub-module `pixel_tick_gen` (parameter CLK_DIV; ports clk, rst_n, tick) implements the divider. The raster counters and decode stay in `vga_timing_gen`.

## Test plan
- Reset release, CLK_DIV = 4 → on the 4th rising edge h_val = 0, v_val = 0, and pix_tick, line_start, frame_start, video_on = 1. Before that edge: h_val = 799, v_val = 524, hsync = vsync = 1.
- Run one full line → h_val counts 0..799, each value held 4 clks.
  - hsync = 0 exactly for h_val 656..751 (384 clks).
  - video_on falls at h_val = 640.
  - line_start high once per 3200 clks.
- Run a full frame → vsync = 0 for lines 490..491 (1600 pixels). v_val wraps 524 → 0 together with h 799 → 0, and frame_start pulses exactly once per 1,680,000 clks.
- CLK_DIV = 1 build → pix_tick constantly high after the first edge, line period 800 clks, and all decodes aligned with counters in every cycle.
- Assert rst_n low at h_val = 300, v_val = 200 for 3 clks → outputs return to their reset values asynchronously, before the next clk edge. The first advance after release yields (0,0) with frame_start.
- SYNC_ACTIVE = 1 build → hsync/vsync polarity inverted, all other outputs unchanged vs. the default run.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and total-length helper
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_CLK_DIV    = 4;
    localparam bit DEF_SYNC_ACTIVE = 1'b0;

    // Counters are 10 bits wide, so neither raster dimension may exceed this.
    localparam int MAX_TOTAL = 1024;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - divides the system clock into a pixel-rate advance enable
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be in 1..16");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= 4'd0;
        end else if (div == DIV_LAST) begin
            div <= 4'd0;
        end else begin
            div <= div + 4'd1;
        end
    end

    // With CLK_DIV = 1 the counter sits at 0 and the enable is permanently high.
    assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster counters, syncs and strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_val,
    output logic [9:0] v_val,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic       tick;
    logic       h_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       hs_act;
    logic       vs_act;
    logic       vo_nxt;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        h_nxt  = h_val;
        v_nxt  = v_val;
        h_wrap = 1'b0;
        if (tick) begin
            if (h_val == H_LAST) begin
                h_nxt  = 10'd0;
                h_wrap = 1'b1;
                v_nxt  = (v_val == V_LAST) ? 10'd0 : v_val + 10'd1;
            end else begin
                h_nxt = h_val + 10'd1;
            end
        end
    end

    // Decoding the next-state counters keeps registered decodes aligned with h_val/v_val.
    always_comb begin
        hs_act = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
        vs_act = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
        vo_nxt = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_val       <= H_LAST;
            v_val       <= V_LAST;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_val       <= h_nxt;
            v_val       <= v_nxt;
            hsync       <= hs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= vs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on    <= vo_nxt;
            pix_tick    <= tick;
            line_start  <= tick && h_wrap;
            frame_start <= tick && h_wrap && (v_nxt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;

    logic [9:0] d_h, d_v, f_h, f_v, m_h, m_v;
    logic d_hs, d_vs, d_vo, d_pt, d_ls, d_fs;
    logic f_hs, f_vs, f_vo, f_pt, f_ls, f_fs;
    logic m_hs, m_vs, m_vo, m_pt, m_ls, m_fs;

    int def_hs_low, def_ls_cnt, mini_fs_cnt, mini_vs_cnt, fast_vs_cnt;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .h_val(d_h), .v_val(d_v), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_vo), .pix_tick(d_pt), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(1), .SYNC_ACTIVE(1'b1)
    ) u_fast (
        .clk(clk), .rst_n(rst_n), .h_val(f_h), .v_val(f_v), .hsync(f_hs), .vsync(f_vs),
        .video_on(f_vo), .pix_tick(f_pt), .line_start(f_ls), .frame_start(f_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(3), .SYNC_ACTIVE(1'b0)
    ) u_mini (
        .clk(clk), .rst_n(rst_n), .h_val(m_h), .v_val(m_v), .hsync(m_hs), .vsync(m_vs),
        .video_on(m_vo), .pix_tick(m_pt), .line_start(m_ls), .frame_start(m_fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected raster state from the number of rising edges since reset release.
    task automatic cmp_inst(input string nm, input int cd, input int ha, input int hf,
                            input int hsw, input int hb, input int va, input int vf,
                            input int vsw, input int vb, input bit sa,
                            input int h, input int v, input int hs, input int vs,
                            input int vo, input int pt, input int ls, input int fs);
        int ht, vt, p, eh, ev, ept, els;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (cyc < cd) begin
            eh  = ht - 1;
            ev  = vt - 1;
            ept = 0;
        end else begin
            p   = cyc / cd - 1;
            eh  = p % ht;
            ev  = (p / ht) % vt;
            ept = (cyc % cd == 0) ? 1 : 0;
        end
        els = (ept == 1 && eh == 0) ? 1 : 0;
        check({nm, "_h"}, h, eh);
        check({nm, "_v"}, v, ev);
        check({nm, "_hsync"}, hs, (eh >= ha + hf && eh < ha + hf + hsw) ? int'(sa) : int'(!sa));
        check({nm, "_vsync"}, vs, (ev >= va + vf && ev < va + vf + vsw) ? int'(sa) : int'(!sa));
        check({nm, "_video_on"}, vo, (eh < ha && ev < va) ? 1 : 0);
        check({nm, "_pix_tick"}, pt, ept);
        check({nm, "_line_start"}, ls, els);
        check({nm, "_frame_start"}, fs, (els == 1 && ev == 0) ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            cmp_inst("def", 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                     int'(d_h), int'(d_v), int'(d_hs), int'(d_vs),
                     int'(d_vo), int'(d_pt), int'(d_ls), int'(d_fs));
            cmp_inst("fast", 1, 8, 2, 3, 3, 4, 1, 2, 2, 1'b1,
                     int'(f_h), int'(f_v), int'(f_hs), int'(f_vs),
                     int'(f_vo), int'(f_pt), int'(f_ls), int'(f_fs));
            cmp_inst("mini", 3, 8, 2, 3, 3, 4, 1, 2, 2, 1'b0,
                     int'(m_h), int'(m_v), int'(m_hs), int'(m_vs),
                     int'(m_vo), int'(m_pt), int'(m_ls), int'(m_fs));
            if (cyc >= 4 && cyc < 3204) begin
                def_hs_low += (d_hs == 1'b0) ? 1 : 0;
                def_ls_cnt += int'(d_ls);
            end
            if (cyc >= 3 && cyc < 435) mini_vs_cnt += (m_vs == 1'b0) ? 1 : 0;
            if (cyc >= 1 && cyc < 145) fast_vs_cnt += int'(f_vs);
            mini_fs_cnt += int'(m_fs);
            case (cyc)
                3: begin
                    check("dir_pre_h", int'(d_h), 799);
                    check("dir_pre_v", int'(d_v), 524);
                    check("dir_pre_hsync", int'(d_hs), 1);
                    check("dir_pre_vsync", int'(d_vs), 1);
                end
                4: begin
                    check("dir_first_h", int'(d_h), 0);
                    check("dir_first_fs", int'(d_fs), 1);
                    check("dir_first_vo", int'(d_vo), 1);
                end
                2564: begin
                    check("dir_h640", int'(d_h), 640);
                    check("dir_vo_off", int'(d_vo), 0);
                end
                2627: check("dir_hs_before", int'(d_hs), 1);
                2628: check("dir_hs_start", int'(d_hs), 0);
                3207: check("dir_hs_end_prev", int'(d_hs), 1);
                3204: begin
                    check("dir_line1_v", int'(d_v), 1);
                    check("dir_line1_ls", int'(d_ls), 1);
                    check("dir_line1_fs", int'(d_fs), 0);
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_def_h"}, int'(d_h), 799);
        check({nm, "_def_v"}, int'(d_v), 524);
        check({nm, "_def_hsync"}, int'(d_hs), 1);
        check({nm, "_def_vsync"}, int'(d_vs), 1);
        check({nm, "_def_strobes"}, int'({d_vo, d_pt, d_ls, d_fs}), 0);
        check({nm, "_fast_hv"}, int'({f_h, f_v}), (15 << 10) | 8);
        check({nm, "_fast_syncs"}, int'({f_hs, f_vs}), 0);
        check({nm, "_mini_syncs"}, int'({m_hs, m_vs}), 3);
        check({nm, "_mini_strobes"}, int'({m_vo, m_pt, m_ls, m_fs}), 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        def_hs_low = 0;
        def_ls_cnt = 0;
        mini_fs_cnt = 0;
        mini_vs_cnt = 0;
        fast_vs_cnt = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        run(3300);
        check("def_hsync_clks", def_hs_low, 384);
        check("def_line_starts", def_ls_cnt, 1);
        check("mini_frame_starts", mini_fs_cnt, 8);
        check("mini_vsync_clks", mini_vs_cnt, 96);
        check("fast_vsync_clks", fast_vs_cnt, 32);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("held");
        rst_n = 1'b1;
        cyc = 0;
        run(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
